dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory (one write port, asynchronous read) between the core load/store path and a debug/loader port.
- The core path has priority so single-cycle execution is undisturbed.
- A starvation counter guarantees the debug port a slot within MAX_WAIT contended cycles.
- The core is stalled while it loses arbitration.
- The block sits between the core datapath (ALU address, ReadData2, MemWrite) and the data memory instance.

Parameters:
ADDR_W, 10, data memory word-address width (matches the data memory address slice)
DATA_W, 32, data width
MAX_WAIT, 4, maximum consecutive contended cycles the debug port may lose before it is forced a grant (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
core_req  in  1  core memory access this cycle (MemRead | MemWrite)
core_we  in  1  core write (MemWrite)
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core store data
core_rdata  out  DATA_W  core load data, combinational from memory when core_gnt
core_gnt  out  1  core access performed this cycle
core_stall  out  1  core_req & ~core_gnt; freezes PC and register write
dbg_req  in  1  debug access request; held with dbg_we/addr/wdata stable until dbg_gnt
dbg_we  in  1  debug write
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  debug access performed this cycle
dbg_rdata  out  DATA_W  registered debug read data
dbg_rvalid  out  1  one-cycle pulse, cycle after a granted debug read
mem_we  out  1  to data memory MemWrite
mem_addr  out  ADDR_W  to data memory Address
mem_wdata  out  DATA_W  to data memory WriteData
mem_rdata  in  DATA_W  from data memory ReadData

Behaviour:
- Reset (rst==0 at posedge):
  - dbg_rdata=0, dbg_rvalid=0, wait_cnt=0, owner=OWN_NONE.
  - Grant logic is forced idle while rst==0: core_gnt=dbg_gnt=mem_we=0, core_stall=0.
- Grant (combinational, from request inputs plus registered wait_cnt):
  - Only core_req: core_gnt=1.
  - Only dbg_req: dbg_gnt=1.
  - Both requesting: dbg_gnt=1 if wait_cnt==MAX_WAIT, else core_gnt=1.
  - Neither requesting: no grant.
  - core_gnt and dbg_gnt are never both 1.
- Memory routing:
  - mem_addr/mem_wdata take the granted requester's address and data.
  - mem_we = granted requester's we.
  - No grant: mem_we=0 and mem_addr=core_addr.
- core_rdata = mem_rdata, zero-latency, valid when core_gnt & ~core_we.
- Debug read: on a posedge with dbg_gnt & ~dbg_we, dbg_rdata<=mem_rdata and dbg_rvalid<=1. dbg_rvalid is 0 on the following cycle unless another debug read is granted.
- Debug write: no dbg_rvalid.
- wait_cnt (4-bit, saturating at MAX_WAIT):
  - Increments when dbg_req & ~dbg_gnt.
  - Clears to 0 on dbg_gnt or when dbg_req==0.
- owner register (last grant: OWN_NONE / OWN_CORE / OWN_DBG) updates every cycle; it is for debug visibility and assertions only.
- Core stall handshake: a stalled core holds core_req/we/addr/wdata stable. A forced debug grant stalls the core for exactly 1 cycle, and the core is granted the next cycle unless core_req drops.
- Boundaries:
  - Back-to-back debug requests under continuous core traffic give debug 1 grant per MAX_WAIT+1 cycles.
  - Debug deasserting dbg_req before its grant clears wait_cnt, and no access occurs.
  - Reset during a pending debug read drops that dbg_rvalid.
  - Writes to the same address from both ports in different cycles apply in grant order.

Decomposition:
- mips_pkg gains: typedef enum logic [1:0] t_dmem_owner {OWN_NONE, OWN_CORE, OWN_DBG}, and constant DMEM_MAX_WAIT_DEFAULT=4.
- One natural sub-module: dmem_wait_counter. It is the saturating starvation counter, with inputs inc, clr and sat_val, and output cnt/at_max.
- The top-level instantiates the counter, holds the owner register and the debug response register, and the core top-level instantiates dmem_arbiter in front of the data memory.

Test Plan:
- Core alone: core_req=1, we=1, addr=0x010, wdata=0xDEADBEEF, then read 0x010 -> core_gnt=1 both cycles, core_stall=0, core_rdata=0xDEADBEEF same cycle.
- Debug alone: dbg write 0x020=0x12345678, then dbg read 0x020 -> dbg_gnt on each request cycle; dbg_rvalid=1 with dbg_rdata=0x12345678 the cycle after the read grant.
- Contention, MAX_WAIT=4: core_req=1 and dbg_req=1 held continuously -> core granted cycles 0-3, dbg_gnt cycle 4 with core_stall=1, core granted cycle 5; pattern repeats every 5 cycles.
- Debug withdraw: dbg_req high 2 contended cycles then low 1 cycle then high -> wait_cnt 1,2,0,1; no dbg_gnt within that window.
- Reset mid-read: dbg read granted, rst=0 at next posedge -> dbg_rvalid=0, dbg_rdata=0, wait_cnt=0, all grants 0 while rst=0.
- Exclusivity assertion over 10k random cycles: never core_gnt & dbg_gnt; mem_we==0 whenever no grant; core_stall == core_req & ~core_gnt.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// load/store path and the debug/loader port.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DBG
  } t_dmem_owner;

  localparam int DMEM_MAX_WAIT_DEFAULT = 4;
  localparam int DMEM_WAIT_W           = 4;

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating starvation counter: counts consecutive cycles the debug port
// has been refused, stopping at sat_val.
module dmem_wait_counter
  import dmem_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clr,
  input  logic [DMEM_WAIT_W-1:0] sat_val,
  output logic [DMEM_WAIT_W-1:0] cnt,
  output logic                   at_max
);

  logic [DMEM_WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt < sat_val)) begin
      r_cnt <= r_cnt + {{(DMEM_WAIT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt    = r_cnt;
  assign at_max = (r_cnt == sat_val);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core (priority) and a
// debug/loader port that is guaranteed a slot after MAX_WAIT refused cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DMEM_MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_gnt,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic                   w_core_gnt;
  logic                   w_dbg_gnt;
  logic                   w_at_max;
  logic [DMEM_WAIT_W-1:0] w_wait_cnt;
  logic                   w_wait_inc;
  logic                   w_wait_clr;
  t_dmem_owner            r_owner;
  t_dmem_owner            w_owner_next;
  logic [DATA_W-1:0]      r_dbg_rdata;
  logic                   r_dbg_rvalid;

  // A withdrawn debug request forfeits its accumulated wait.
  assign w_wait_inc = dbg_req & ~w_dbg_gnt;
  assign w_wait_clr = w_dbg_gnt | ~dbg_req;

  dmem_wait_counter u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_wait_inc),
    .clr     (w_wait_clr),
    .sat_val (DMEM_WAIT_W'(MAX_WAIT)),
    .cnt     (w_wait_cnt),
    .at_max  (w_at_max)
  );

  // Grant decision; the core wins every contended cycle unless debug is starved.
  always_comb begin
    w_core_gnt = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (rst) begin
      if (dbg_req && (!core_req || w_at_max)) begin
        w_dbg_gnt = 1'b1;
      end else if (core_req) begin
        w_core_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_core_gnt) begin
      w_owner_next = OWN_CORE;
    end else if (w_dbg_gnt) begin
      w_owner_next = OWN_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
      if (w_dbg_gnt && !dbg_we) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (w_dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (w_core_gnt) begin
      mem_we    = core_we;
    end
  end

  assign core_gnt   = w_core_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign core_stall = rst & core_req & ~w_core_gnt;
  assign core_rdata = mem_rdata;
  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;

  a_grant_exclusive : assert property (@(posedge clk) !(w_core_gnt && w_dbg_gnt));
  a_rvalid_owner    : assert property (@(posedge clk) r_dbg_rvalid |-> (r_owner == OWN_DBG));
  a_wait_in_range   : assert property (@(posedge clk) w_wait_cnt <= DMEM_WAIT_W'(MAX_WAIT));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a reference model predicts each
// cycle's response, a negedge monitor pops and compares it.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we, dbg_req, dbg_we;
  logic [AW-1:0] core_addr, dbg_addr;
  logic [DW-1:0] core_wdata, dbg_wdata;
  logic [DW-1:0] core_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          core_gnt, core_stall, dbg_gnt, dbg_rvalid, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_gnt(core_gnt),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Environment data memory: asynchronous read, written once per cycle.
  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  assign mem_rdata = tb_mem[mem_addr];

  typedef struct {
    logic          cg, dg, stall, we;
    logic [AW-1:0] addr;
    logic          chk_wdata;
    logic [DW-1:0] wdata;
    logic          chk_crd;
    logic [DW-1:0] crd;
    logic          rv;
    logic [DW-1:0] rd;
    logic [3:0]    wc;
  } t_exp;

  t_exp          exp_q[$];
  t_exp          mon_e;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_wait;
  logic          m_rv;
  logic [DW-1:0] m_rd;
  logic          cur_cg, cur_dg;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("core_gnt",   DW'(core_gnt),   DW'(mon_e.cg));
      chk("dbg_gnt",    DW'(dbg_gnt),    DW'(mon_e.dg));
      chk("core_stall", DW'(core_stall), DW'(mon_e.stall));
      chk("mem_we",     DW'(mem_we),     DW'(mon_e.we));
      chk("mem_addr",   DW'(mem_addr),   DW'(mon_e.addr));
      chk("dbg_rvalid", DW'(dbg_rvalid), DW'(mon_e.rv));
      chk("dbg_rdata",  dbg_rdata,       mon_e.rd);
      chk("wait_cnt",   DW'(dut.w_wait_cnt), DW'(mon_e.wc));
      if (mon_e.chk_wdata) chk("mem_wdata", mem_wdata, mon_e.wdata);
      if (mon_e.chk_crd)   chk("core_rdata", core_rdata, mon_e.crd);
      $display("cyc t=%0t rst=%0b creq=%0b dreq=%0b cg=%0b dg=%0b stall=%0b we=%0b addr=%h rv=%0b wc=%0d",
               $time, rst, core_req, dbg_req, core_gnt, dbg_gnt, core_stall, mem_we,
               mem_addr, dbg_rvalid, dut.w_wait_cnt);
    end
  end

  // Reference: core wins contention unless debug has already lost MW cycles in a row.
  task automatic step();
    t_exp          e;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    e.cg = 1'b0;
    e.dg = 1'b0;
    if (rst) begin
      if (core_req && dbg_req) begin
        e.dg = (m_wait == MW);
        e.cg = !e.dg;
      end else begin
        e.cg = core_req;
        e.dg = dbg_req;
      end
    end
    e.stall     = rst & core_req & ~e.cg;
    e.we        = e.cg ? core_we : (e.dg ? dbg_we : 1'b0);
    e.addr      = e.dg ? dbg_addr : core_addr;
    e.chk_wdata = (e.cg && core_we) || (e.dg && dbg_we);
    e.wdata     = e.dg ? dbg_wdata : core_wdata;
    e.chk_crd   = e.cg && !core_we;
    e.crd       = ref_mem[core_addr];
    e.rv        = m_rv;
    e.rd        = m_rd;
    e.wc        = 4'(m_wait);
    exp_q.push_back(e);
    cur_cg = e.cg;
    cur_dg = e.dg;
    @(negedge clk);
    cap_we    = mem_we;
    cap_addr  = mem_addr;
    cap_wdata = mem_wdata;
    @(posedge clk);
    if (!rst) begin
      m_wait = 0;
      m_rv   = 1'b0;
      m_rd   = '0;
    end else begin
      m_rv = e.dg && !dbg_we;
      if (m_rv) m_rd = ref_mem[dbg_addr];
      if (e.cg && core_we) ref_mem[core_addr] = core_wdata;
      if (e.dg && dbg_we)  ref_mem[dbg_addr]  = dbg_wdata;
      if (dbg_req && !e.dg) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else                  m_wait = 0;
    end
    #1;
    if (cap_we) tb_mem[cap_addr] = cap_wdata;
  endtask

  task automatic drive(input logic r, input logic cr, input logic cw,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    rst = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      tb_mem[i]  = DW'(i) * 32'h9E37_79B1;
      ref_mem[i] = DW'(i) * 32'h9E37_79B1;
    end
    m_wait = 0; m_rv = 1'b0; m_rd = '0; cur_cg = 1'b0; cur_dg = 1'b0;
    rst = 1'b0; core_req = 1'b1; core_we = 1'b1; core_addr = '0; core_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    @(posedge clk); #1;
    m_rv = 1'b0; m_rd = '0; m_wait = 0;

    // Reset with both ports requesting: everything idle.
    drive(0, 1, 1, 10'h005, 32'h1, 1, 1, 10'h006, 32'h2);
    drive(0, 1, 0, 10'h005, 32'h0, 1, 0, 10'h006, 32'h0);
    // Core alone: store then same-cycle load.
    drive(1, 1, 1, 10'h010, 32'hDEAD_BEEF, 0, 0, 10'h000, 32'h0);
    drive(1, 1, 0, 10'h010, 32'h0, 0, 0, 10'h000, 32'h0);
    // Debug alone: write, read, then observe the registered response.
    drive(1, 0, 0, 10'h000, 32'h0, 1, 1, 10'h020, 32'h1234_5678);
    drive(1, 0, 0, 10'h000, 32'h0, 1, 0, 10'h020, 32'h0);
    drive(1, 0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0);
    // Continuous contention: debug wins one cycle in every MW+1.
    for (int i = 0; i < 12; i++) drive(1, 1, 0, 10'h030, 32'h0, 1, 0, 10'h040, 32'h0);
    drive(1, 0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0);
    // Debug withdraws before being served.
    drive(1, 1, 0, 10'h031, 32'h0, 1, 1, 10'h041, 32'h55);
    drive(1, 1, 0, 10'h031, 32'h0, 1, 1, 10'h041, 32'h55);
    drive(1, 1, 0, 10'h031, 32'h0, 0, 0, 10'h041, 32'h55);
    drive(1, 1, 0, 10'h031, 32'h0, 1, 1, 10'h041, 32'h55);
    drive(1, 0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0);
    // Reset right after a granted debug read.
    drive(1, 0, 0, 10'h000, 32'h0, 1, 0, 10'h020, 32'h0);
    drive(0, 1, 0, 10'h000, 32'h0, 1, 0, 10'h020, 32'h0);
    drive(0, 1, 0, 10'h000, 32'h0, 1, 0, 10'h020, 32'h0);

    // Random traffic honouring the stall and debug-hold handshakes.
    for (int i = 0; i < 10000; i++) begin
      logic keep_core, keep_dbg;
      keep_core = rst && core_req && !cur_cg;
      keep_dbg  = dbg_req && !cur_dg && ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) != 0);
      if (!keep_core) begin
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = AW'($urandom_range(0, 15));
        core_wdata = $urandom;
      end
      if (!keep_dbg) begin
        dbg_req   = ($urandom_range(0, 2) == 0);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = AW'($urandom_range(0, 15));
        dbg_wdata = $urandom;
      end
      step();
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
